mul_core: RTL and testbench
===========================

# mul_core

Iterative unsigned multiplier: it accepts one operand pair through a valid/ready handshake and computes the product with a radix-2 shift-add datapath, one bit per clock. It presents the registered full-width product through a second valid/ready handshake. The block sits behind the multiplier bus interface and is the only datapath element on it; all signals share a single clock.

## Interface
- WIDTH, default 8: operand width in bits; product width is 2*WIDTH. Legal range is 2..32.

- clk  in  1  sole clock; all state updates on rising edge.
- rstn  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  operand pair a/b is valid this cycle.
- in_ready  out  1  block can accept operands; high exactly when state is IDLE.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  product valid; high exactly when state is DONE.
- out_ready  in  1  consumer accepts the product this cycle.
- product  out  2*WIDTH  registered result a*b, unsigned.

## Operation
- States: IDLE, BUSY, DONE, with a step counter 0..WIDTH-1.
- Internal registers: multiplicand register (2*WIDTH bits), multiplier register (WIDTH bits), accumulator (2*WIDTH bits), counter.
- IDLE: in_ready=1. Acceptance is in_valid && in_ready sampled at a rising edge. On acceptance:
  - latch a zero-extended into the multiplicand register, and b into the multiplier register;
  - clear the accumulator and counter;
  - go to BUSY.
- BUSY, each edge:
  - if the multiplier register LSB is 1, add the multiplicand register to the accumulator;
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - increment the counter.
  - After the step with counter = WIDTH-1: copy the final sum to product and go to DONE.
- DONE: out_valid=1, product held stable. Handshake is out_valid && out_ready at an edge; on handshake go to IDLE. While out_ready=0 the block stays in DONE indefinitely with product unchanged.
- Arithmetic: unsigned, exact, no overflow possible; product = a*b mod 2^(2*WIDTH), which equals a*b.
- in_valid while not IDLE is ignored; no operand is queued. a/b may change after acceptance without effect.
- product retains the last result in IDLE and BUSY; out_valid is the sole indicator of validity.
- Reset (rstn=0 at an edge), in any state including mid-BUSY:
  - state goes to IDLE and any in-flight operation is discarded;
  - product, accumulator, counter and operand registers are cleared to 0.
  - After the reset edge: in_ready=1, out_valid=0, product=0.
  - Reset has priority over any handshake in the same cycle.

## Timing
- All outputs are derived from registers only; no combinational path from inputs to outputs.
- Acceptance at edge E0; BUSY steps at edges E1..E_WIDTH; out_valid=1 from just after E_WIDTH.
- Latency: WIDTH cycles from the acceptance edge to out_valid (8 for default).
- If out_ready=1 when out_valid rises, the handshake occurs at edge E_WIDTH+1 and in_ready is high after it.
- Next acceptance is possible at edge E_WIDTH+2 at the earliest, so minimum initiation interval is WIDTH+2 cycles.
- in_ready and out_valid are never high simultaneously.
- While rstn=0: in_ready=1, out_valid=0, product=0 from the first reset edge onward.

## Test plan
- Reset then a=3, b=5 with in_valid for one cycle, out_ready=1 -> out_valid rises exactly 8 cycles after acceptance with product=15; out_valid lasts 1 cycle; in_ready high the next cycle.
- Corners: a=255, b=255 -> 65025 (0xFE01); a=0, b=200 -> 0; a=1, b=255 -> 255; a=128, b=2 -> 256.
- Backpressure: a=12, b=11, out_ready=0 for 20 cycles after out_valid -> product=132 held stable, in_valid pulses meanwhile ignored (in_ready=0); releasing out_ready completes the handshake in 1 cycle.
- Reset mid-operation: a=9, b=7 accepted, rstn=0 at the 4th BUSY edge -> in_ready=1, out_valid=0, product=0; the subsequent a=2, b=3 -> 6.
- Back-to-back: in_valid held high with a changing each cycle and out_ready=1 -> each accepted pair produces the correct product; accepts are spaced by 10 cycles.
- Random: 1000 uniform unsigned pairs with random out_ready -> every product equals a*b and latency is 8 cycles each.

Source files
------------

// File: rtl/mul_if.sv
// Multiplier bus: the operand handshake (in_valid/in_ready, a, b) and the
// product handshake (out_valid/out_ready, product).
//   master: producer of operands and consumer of products (drives in_valid,
//           a, b, out_ready)
//   slave : the multiplier (drives in_ready, out_valid, product)
interface mul_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, product);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, product);
endinterface

// File: rtl/mul_core.sv
// Iterative unsigned multiplier, radix-2 shift-add, one multiplier bit per
// clock. Accepts a/b when idle, spends WIDTH cycles in BUSY, then holds the
// product in DONE until the consumer takes it.
//   clk  : sole clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : mul_if slave (operand and product handshakes)
module mul_core #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rstn,
  mul_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, acc, prod, sum;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;
  logic               accept, last;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (cnt == CW'(WIDTH - 1));
  // Partial-product add for the current multiplier bit.
  assign sum    = acc + (mplr[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = BUSY;
      BUSY:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand <= {{WIDTH{1'b0}}, bus.a};
          mplr  <= bus.b;
          acc   <= '0;
          cnt   <= '0;
        end
        BUSY: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
          // Final step: the sum already includes the top multiplier bit.
          if (last) prod <= sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = prod;
endmodule

// File: tb/tb_mul_core.sv
module tb_mul_core;
  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  mul_if #(.WIDTH(8)) bus ();
  mul_core #(.WIDTH(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  // Advance one edge; sample/drive 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction. rnd=1 toggles out_ready randomly while waiting.
  task automatic run(input logic [7:0] x, input logic [7:0] y, input bit rnd, input string tag);
    logic [15:0] exp;
    int lat, n;
    exp = 16'(x) * 16'(y);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.a = x; bus.b = y;
    step();                                   // acceptance edge E0
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " product"}, 32'(bus.product), 32'(exp));
    n = 0;
    while (rnd && n < 5 && $urandom_range(0, 1) == 1) begin
      bus.out_ready = 1'b0;
      step();
      n++;
    end
    if (n > 0) chk({tag, " held"}, {31'd0, bus.out_valid} + 32'(bus.product), 32'(exp) + 32'd1);
    bus.out_ready = 1'b1;
    step();                                   // handshake edge
    chk({tag, " drain"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    logic [15:0] q[$];
    int last_acc, cyc;
    bit ok;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    rstn = 1'b0;
    step(); step();
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset product", 32'(bus.product), 32'd0);
    rstn = 1'b1;
    step();

    run(8'd3, 8'd5, 1'b0, "3x5");
    run(8'd255, 8'd255, 1'b0, "255x255");
    run(8'd0, 8'd200, 1'b0, "0x200");
    run(8'd1, 8'd255, 1'b0, "1x255");
    run(8'd128, 8'd2, 1'b0, "128x2");

    // Backpressure: 12*11 held for 20 cycles, in_valid pulses ignored.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'd12; bus.b = 8'd11;
    step();
    bus.in_valid = 1'b0;
    repeat (8) step();
    chk("bp out_valid", 32'(bus.out_valid), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0]; bus.a = 8'(i); bus.b = 8'd99;
      step();
      if (bus.product !== 16'd132 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("bp held", 32'(ok), 32'd1);
    chk("bp product", 32'(bus.product), 32'd132);
    bus.out_ready = 1'b1;
    step();
    chk("bp release", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);

    // Reset at the 4th BUSY edge of 9*7.
    bus.in_valid = 1'b1; bus.a = 8'd9; bus.b = 8'd7;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rstn = 1'b0;
    step();
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst product", 32'(bus.product), 32'd0);
    rstn = 1'b1;
    step();
    run(8'd2, 8'd3, 1'b0, "2x3");

    // Back-to-back: in_valid held, a changes every cycle.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    last_acc = -1;
    for (cyc = 0; cyc < 45; cyc++) begin
      bus.a = 8'(cyc * 7 + 3); bus.b = 8'(250 - cyc);
      if (bus.out_valid) begin
        if (q.size() == 0) chk("b2b spurious", 32'd1, 32'd0);
        else chk("b2b product", 32'(bus.product), 32'(q.pop_front()));
      end
      if (bus.in_ready) begin
        q.push_back(16'(bus.a) * 16'(bus.b));
        if (last_acc >= 0) chk("b2b spacing", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
      end
      step();
    end
    bus.in_valid = 1'b0;
    // Let the last in-flight operation finish.
    for (int i = 0; i < 12 && q.size() > 0; i++) begin
      if (bus.out_valid) chk("b2b tail", 32'(bus.product), 32'(q.pop_front()));
      step();
    end
    chk("b2b drained", 32'(q.size()), 32'd0);
    step();

    // Random pairs with random out_ready.
    for (int i = 0; i < 1000; i++)
      run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
